// File: rtl/mant_add_pipe.sv
// rtl/mant_add_pipe.sv - segmented carry-pipelined add/subtract with valid/ready flow control
// Each stage adds one SEG-bit slice; later operand slices and finished sum slices ride along.
module mant_add_pipe #(
  parameter int WIDTH = 24,
  parameter int SEG   = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = (WIDTH + SEG - 1) / SEG;
  localparam int LAST   = STAGES - 1;

  logic             en;
  logic [WIDTH-1:0] b_mod;
  logic             zero_q;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign b_mod    = in_sub ? ~in_b : in_b;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : stg
    localparam int LO = k * SEG;
    localparam int HI = (k == LAST) ? WIDTH : LO + SEG;
    localparam int W  = HI - LO;

    logic [WIDTH-1:LO] a_src;
    logic [WIDTH-1:LO] b_src;
    logic              c_src;
    logic              v_src;
    logic [TAG_W-1:0]  t_src;
    logic [W:0]        seg_sum;
    logic [HI-1:0]     s_d;
    logic [HI-1:0]     s_q;
    logic              c_q;
    logic              v_q;
    logic [TAG_W-1:0]  t_q;

    if (k == 0) begin : src
      assign a_src = in_a;
      assign b_src = b_mod;
      assign c_src = in_sub;
      assign v_src = in_valid;
      assign t_src = in_tag;
      assign s_d   = seg_sum[W-1:0];
    end else begin : src
      assign a_src = stg[k-1].up.a_q;
      assign b_src = stg[k-1].up.b_q;
      assign c_src = stg[k-1].c_q;
      assign v_src = stg[k-1].v_q;
      assign t_src = stg[k-1].t_q;
      assign s_d   = {seg_sum[W-1:0], stg[k-1].s_q};
    end

    assign seg_sum = {1'b0, a_src[HI-1:LO]} + {1'b0, b_src[HI-1:LO]} + {{W{1'b0}}, c_src};

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
        t_q <= '0;
      end else if (en) begin
        v_q <= v_src;
        c_q <= seg_sum[W];
        s_q <= s_d;
        t_q <= t_src;
      end
    end

    // Operand slices not yet consumed; the last stage has none left to carry.
    if (k < LAST) begin : up
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_src[WIDTH-1:HI];
          b_q <= b_src[WIDTH-1:HI];
        end
      end
    end
  end

  // Zero flag is registered from the final stage's next sum so reset can force it low.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (en) begin
      zero_q <= (stg[LAST].s_d == '0);
    end
  end

  assign out_valid = stg[LAST].v_q;
  assign out_sum   = stg[LAST].s_q;
  assign out_carry = stg[LAST].c_q;
  assign out_tag   = stg[LAST].t_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_mant_add_pipe.sv
// tb/tb_mant_add_pipe.sv - scoreboard bench for mant_add_pipe
module tb_mant_add_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, in_sub, out_valid, out_ready, out_carry, out_zero;
  logic [23:0] in_a, in_b, out_sum;
  logic [3:0]  in_tag, out_tag;

  logic        v22_in_valid, v22_in_ready, v22_out_valid, v22_out_carry, v22_out_zero;
  logic [21:0] v22_out_sum;
  logic [3:0]  v22_out_tag;

  mant_add_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_zero(out_zero), .out_tag(out_tag)
  );

  mant_add_pipe #(.WIDTH(22), .SEG(8), .TAG_W(4)) dut22 (
    .clk(clk), .rst(rst),
    .in_valid(v22_in_valid), .in_ready(v22_in_ready),
    .in_a(22'h3FFFFF), .in_b(22'h3FFFFF), .in_sub(1'b0), .in_tag(4'h9),
    .out_valid(v22_out_valid), .out_ready(1'b1),
    .out_sum(v22_out_sum), .out_carry(v22_out_carry), .out_zero(v22_out_zero), .out_tag(v22_out_tag)
  );

  typedef struct packed {
    logic [23:0] sum;
    logic        carry;
    logic        zero;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n_out  = 0;

  function automatic exp_t model(input logic [23:0] a, input logic [23:0] b,
                                 input logic sub, input logic [3:0] tag);
    exp_t        e;
    logic [24:0] r;
    r = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    e.sum   = r[23:0];
    e.carry = sub ? (a >= b) : r[24];
    e.zero  = (r[23:0] == 24'd0);
    e.tag   = tag;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_sum",   {8'd0, out_sum}, {8'd0, e.sum});
          chk("sb_carry", {31'd0, out_carry}, {31'd0, e.carry});
          chk("sb_zero",  {31'd0, out_zero}, {31'd0, e.zero});
          chk("sb_tag",   {28'd0, out_tag}, {28'd0, e.tag});
        end
        n_out++;
      end
      if (in_valid && in_ready) sb.push_back(model(in_a, in_b, in_sub, in_tag));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [23:0] a, input logic [23:0] b, input logic sub, input logic [3:0] tag);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_sub = sub;
    in_tag = tag;
  endtask

  task automatic send_op(input logic [23:0] a, input logic [23:0] b, input logic sub, input logic [3:0] tag);
    int n;
    n = 0;
    drive(a, b, sub, tag);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", {31'd0, in_ready}, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 32'(n < 50), 1);
  endtask

  initial begin
    exp_t e1;
    int   base;
    int   n;
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    v22_in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_sum",   {8'd0, out_sum}, 0);
    chk("rst_out_carry", {31'd0, out_carry}, 0);
    chk("rst_out_zero",  {31'd0, out_zero}, 0);
    chk("rst_out_tag",   {28'd0, out_tag}, 0);
    chk("rst_in_ready",  {31'd0, in_ready}, 1);

    // Carry ripples through all three segments; exact three-cycle latency.
    step();
    drive(24'hFFFFFF, 24'h000001, 1'b0, 4'h5);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_c1_valid", {31'd0, out_valid}, 0);
    step();
    @(negedge clk);
    chk("lat_c2_valid", {31'd0, out_valid}, 0);
    step();
    @(negedge clk);
    chk("lat_c3_valid", {31'd0, out_valid}, 1);
    chk("wrap_sum",     {8'd0, out_sum}, 0);
    chk("wrap_carry",   {31'd0, out_carry}, 1);
    chk("wrap_zero",    {31'd0, out_zero}, 1);
    wait_idle();

    step();
    send_op(24'h000005, 24'h000007, 1'b1, 4'h6);
    send_op(24'h000007, 24'h000005, 1'b1, 4'h7);
    send_op(24'h123456, 24'h123456, 1'b1, 4'h8);
    send_op(24'h800000, 24'h800000, 1'b0, 4'h9);
    wait_idle();

    // Back-to-back: four results on consecutive cycles starting three cycles after the first accept.
    for (int i = 0; i < 8; i++) begin
      step();
      if (i < 4) drive(24'(i * 24'h010101), 24'h00FF01, i[0], 4'(i + 1));
      else in_valid = 1'b0;
      @(negedge clk);
      if (i >= 3 && i <= 6) begin
        chk("b2b_valid", {31'd0, out_valid}, 1);
        chk("b2b_tag",   {28'd0, out_tag}, 32'(i - 2));
      end else begin
        chk("b2b_idle", {31'd0, out_valid}, 0);
      end
    end
    wait_idle();

    // Backpressure: fill the pipe, hold off the consumer, then release.
    base = n_out;
    step();
    out_ready = 1'b0;
    e1 = model(24'h00F00F, 24'h0F00F0, 1'b0, 4'hA);
    send_op(24'h00F00F, 24'h0F00F0, 1'b0, 4'hA);
    send_op(24'h000100, 24'h000200, 1'b1, 4'hB);
    send_op(24'hABCDEF, 24'h111111, 1'b0, 4'hC);
    drive(24'h000010, 24'h000010, 1'b1, 4'hD);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 0);
      chk("stall_valid",    {31'd0, out_valid}, 1);
      chk("stall_sum",      {8'd0, out_sum}, {8'd0, e1.sum});
      chk("stall_carry",    {31'd0, out_carry}, {31'd0, e1.carry});
      chk("stall_tag",      {28'd0, out_tag}, {28'd0, e1.tag});
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_retire_accept", {31'd0, in_ready && out_valid}, 1);
    step();
    in_valid = 1'b0;
    send_op(24'h7FFFFF, 24'h000001, 1'b0, 4'hE);
    wait_idle();
    chk("stall_count", 32'(n_out - base), 5);

    // Reset with operations in flight, plus an offer during reset that must be dropped.
    base = n_out;
    send_op(24'h000111, 24'h000222, 1'b0, 4'h1);
    send_op(24'h000333, 24'h000444, 1'b0, 4'h2);
    rst = 1'b1;
    drive(24'h000555, 24'h000666, 1'b0, 4'h3);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, out_valid}, 0);
    chk("post_rst_ready", {31'd0, in_ready}, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      chk("flushed_valid", {31'd0, out_valid}, 0);
    end
    chk("flushed_count", 32'(n_out - base), 0);

    step();
    for (int i = 0; i < 16; i++) begin
      send_op(24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)), 4'(i));
    end
    wait_idle();

    // 22-bit instance: 6-bit top segment.
    step();
    v22_in_valid = 1'b1;
    step();
    v22_in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!v22_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("w22_latency", 32'(n), 2);
    chk("w22_sum",   {10'd0, v22_out_sum}, 32'h3FFFFE);
    chk("w22_carry", {31'd0, v22_out_carry}, 1);
    chk("w22_zero",  {31'd0, v22_out_zero}, 0);
    chk("w22_tag",   {28'd0, v22_out_tag}, 32'h9);

    chk("sb_empty_end", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mant_add_pipe.md
MANT_ADD_PIPE -- requirements
Module: mant_add_pipe

Interface
REQ-001 Parameter WIDTH, default 24: operand/result width in bits, at least 2.
REQ-002 Parameter SEG, default 8: bits added per pipeline stage, 1 to WIDTH.
REQ-003 Parameter TAG_W, default 4: width of sideband tag carried alongside each operation.
REQ-004 Derived STAGES = ceil(WIDTH/SEG); the top segment is WIDTH - (STAGES-1)*SEG bits wide.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  operation offered.
REQ-008 in_ready  output  1  block can accept the offered operation this cycle.
REQ-009 in_a  input  WIDTH  operand A.
REQ-010 in_b  input  WIDTH  operand B.
REQ-011 in_sub  input  1  0 = A+B, 1 = A-B.
REQ-012 in_tag  input  TAG_W  sideband, returned unchanged with the result.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer accepts the result this cycle.
REQ-015 out_sum  output  WIDTH  result modulo 2^WIDTH.
REQ-016 out_carry  output  1  carry out of MSB; for subtract, 1 iff A >= B unsigned.
REQ-017 out_zero  output  1  out_sum equals zero.
REQ-018 out_tag  output  TAG_W  tag of the returned operation.

Function
REQ-019 The block SHALL have STAGES register stages: stage k adds segment k of the operands plus the carry registered by stage k-1, and stage 0 takes carry-in = in_sub.
REQ-020 Subtract SHALL be computed as A + ~B + 1, with B inverted before the stage 0 register.
REQ-021 Unprocessed upper operand segments and completed lower sum segments SHALL be delay-registered to stay aligned with their operation.
REQ-022 Each stage SHALL hold a valid bit, and tag and sub SHALL travel with that stage's valid bit.
REQ-023 Global advance enable en = !out_valid || out_ready; when en = 0, every stage register SHALL hold its value.
REQ-024 in_ready SHALL equal en; this is a combinational path from out_ready.
REQ-025 An operation SHALL be accepted iff in_valid && in_ready; if in_valid = 0 while en = 1, a bubble (valid 0) SHALL enter stage 0.
REQ-026 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when out_ready is held at 1.
REQ-027 Throughput SHALL be one operation per cycle, including a cycle in which the full pipe retires one operation and accepts one.
REQ-028 Bubbles are not collapsed; results SHALL emerge in acceptance order, with no loss and no duplication.
REQ-029 While out_valid && !out_ready, all out_* signals SHALL remain stable.
REQ-030 out_zero SHALL be derived from the final registered sum and be valid in the same cycle as out_sum.
REQ-031 When STAGES = 1, the block SHALL behave as a single-register adder with the same handshake.

Reset
REQ-032 On rst = 1 at a clock edge, all stage valid bits and out_valid SHALL clear to 0, and out_sum, out_carry, out_zero and out_tag SHALL clear to 0.
REQ-033 In-flight operations at reset SHALL be discarded and never presented.
REQ-034 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-035 rst SHALL take priority over any simultaneous handshake.

Verification (WIDTH=24, SEG=8, STAGES=3 unless stated)
REQ-036 Add 0xFFFFFF + 0x000001 with out_ready = 1 -> 3 cycles later out_sum = 0x000000, out_carry = 1, out_zero = 1.
REQ-037 Subtract 0x000005 - 0x000007 -> out_sum = 0xFFFFFE, out_carry = 0, out_zero = 0; subtract 0x000007 - 0x000005 -> out_sum = 0x000002, out_carry = 1.
REQ-038 Four back-to-back ops, tags 1..4, out_ready = 1 -> out_valid high on four consecutive cycles starting 3 cycles after the first accept, tags 1,2,3,4.
REQ-039 Fill the pipe, then hold out_ready = 0 for 5 cycles -> in_ready = 0, outputs frozen; after release, all ops emerge in order, none lost.
REQ-040 Assert rst with 2 ops in flight -> out_valid = 0 from the next cycle and neither op ever appears; in_ready = 1 after rst drops.
REQ-041 WIDTH=22, SEG=8 (6-bit top segment): 0x3FFFFF + 0x3FFFFF -> out_sum = 0x3FFFFE, out_carry = 1.
